apb_regfile_slave: RTL
======================

APB_REGFILE_SLAVE -- requirements
Module: apb_regfile_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h4000_0000, meaning the APB base address (bits [31:6] decoded).
REQ-002 SHALL have parameter WAIT_STATES, default 2, range 0..15, meaning the PREADY-low cycles inserted in every access phase.
REQ-003 SHALL have parameter ID_VALUE, default 32'hA5B2_0001, meaning the read-only content of register 0.
REQ-004 SHALL have one clock and an asynchronous active-low reset; all other ports follow, as name, direction, width, meaning:
REQ-005 HCLK  in  1  single clock, rising edge.
REQ-006 HRESETn  in  1  asynchronous active-low reset.
REQ-007 PSEL  in  1  slave select from the bridge.
REQ-008 PENABLE  in  1  access-phase strobe.
REQ-009 PWRITE  in  1  1 = write, 0 = read.
REQ-010 PADDR  in  32  byte address.
REQ-011 PWDATA  in  32  write data.
REQ-012 PRDATA  out  32  read data, valid only while PREADY=1.
REQ-013 PREADY  out  1  transfer completion.
REQ-014 PSLVERR  out  1  error response, valid only while PREADY=1.

Function
REQ-015 SHALL implement 16 x 32-bit registers at word index PADDR[5:2]: reg0 = ID_VALUE (RO), reg1 = STATUS (RO, {16'h0, err_cnt[15:0]}), reg2..reg15 = RW.
REQ-016 SHALL use FSM states IDLE and ACCESS: IDLE -> ACCESS when PSEL=1 and PENABLE=0 are sampled; otherwise stay in IDLE.
REQ-017 SHALL latch PADDR, PWRITE and PWDATA, compute the error flag, and load wait_cnt = WAIT_STATES on the IDLE -> ACCESS edge; the access phase uses only latched values.
REQ-018 SHALL set the error flag when PADDR[31:6] != BASE_ADDR[31:6], or PADDR[1:0] != 0, or the transfer is a write to index 0 or 1.
REQ-019 In ACCESS with PSEL=1 and wait_cnt != 0: PREADY=0 and wait_cnt decrements each cycle.
REQ-020 In ACCESS with PSEL=1 and wait_cnt == 0: PREADY=1 combinationally and PSLVERR = error flag; at that edge the FSM returns to IDLE.
REQ-021 With WAIT_STATES=0, PREADY SHALL be 1 in the first access cycle (zero-wait transfer, total 2 cycles).
REQ-022 On a completing write with no error, SHALL update the register at that edge; an errored write SHALL leave all registers unchanged.
REQ-023 On a completing read, PRDATA = addressed register, or 32'h0 if errored; PRDATA SHALL be 32'h0 whenever PREADY=0.
REQ-024 On each completion with PSLVERR=1, err_cnt SHALL increment, saturating at 16'hFFFF.
REQ-025 If PSEL=0 in ACCESS, SHALL abort to IDLE with no write, no PREADY pulse and no err_cnt change.
REQ-026 In IDLE with PENABLE=1, or with PSEL=0, SHALL stay in IDLE with PREADY=0 (no response to a missing setup phase).
REQ-027 Back-to-back transfers SHALL be supported: a setup phase in the cycle after completion is accepted normally.
REQ-028 Changes on PADDR, PWRITE or PWDATA during ACCESS SHALL be ignored.

Reset
REQ-029 HRESETn=0 SHALL asynchronously force: state IDLE, wait_cnt 0, reg2..reg15 = 0, err_cnt 0, PREADY 0, PSLVERR 0, PRDATA 0.
REQ-030 Reset asserted mid-access SHALL discard the transfer: no write and no response after release.

Structure
REQ-031 The state enum, NUM_REGS=16, ID register index 0 and STATUS register index 1 SHALL live in shared package bridge_pkg.
REQ-032 SHALL be a single module with no sub-module; the register array and FSM are local.

Verification
REQ-033 Write 32'hDEAD_BEEF to 0x4000_0008 with WAIT_STATES=2, then read it back -> PREADY high on the 3rd access cycle each time, PRDATA=32'hDEAD_BEEF, PSLVERR=0.
REQ-034 Read 0x4000_0000, then write 0x4000_0004 -> read returns 32'hA5B2_0001; write gets PSLVERR=1; a read of 0x4000_0004 then returns 32'h0000_0001.
REQ-035 Access 0x5000_0010, then 0x4000_0009 -> both give PSLVERR=1 and PRDATA=0, with no register change.
REQ-036 Drop PSEL after 1 wait cycle of a write of 32'h1234 to 0x4000_000C -> no PREADY pulse; a read of 0x4000_000C returns 32'h0.
REQ-037 Assert HRESETn=0 mid-access after writing 0x55 to reg5 -> outputs 0 immediately; after release, a read of reg5 returns 0 and STATUS returns 0.
REQ-038 With WAIT_STATES=0, drive back-to-back write then read to 0x4000_003C -> each completes in 2 cycles, and the read returns the written data.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared definitions for the APB register-file slave.
// Contents:
//   state_t    - two-state APB slave FSM encoding (IDLE, ACCESS)
//   NUM_REGS   - number of 32-bit registers in the file
//   ID_IDX     - word index of the read-only ID register
//   STATUS_IDX - word index of the read-only STATUS register
package bridge_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int         NUM_REGS   = 16;
  localparam logic [3:0] ID_IDX     = 4'd0;
  localparam logic [3:0] STATUS_IDX = 4'd1;

endpackage

// File: rtl/apb_regfile_slave.sv
// APB slave exposing 16 x 32-bit registers at word index PADDR[5:2].
//   reg0  : ID_VALUE, read-only
//   reg1  : STATUS = {16'h0, err_cnt}, read-only
//   reg2+ : read/write
// Every access phase is stretched by WAIT_STATES PREADY-low cycles.
// Ports:
//   HCLK     in   1  clock, rising edge
//   HRESETn  in   1  asynchronous active-low reset
//   PSEL     in   1  slave select
//   PENABLE  in   1  access-phase strobe
//   PWRITE   in   1  1 = write, 0 = read
//   PADDR    in  32  byte address
//   PWDATA   in  32  write data
//   PRDATA   out 32  read data, zero unless a good read is completing
//   PREADY   out  1  transfer completion
//   PSLVERR  out  1  error response, qualified by PREADY
module apb_regfile_slave
  import bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] ID_VALUE    = 32'hA5B2_0001
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  wait_cnt;
  logic [3:0]  idx_q;
  logic        wr_q;
  logic        err_q;
  logic [31:0] wdata_q;
  logic [15:0] err_cnt;
  logic [31:0] regs [NUM_REGS];

  logic        setup;
  logic        done;
  logic        setup_err;
  logic [31:0] rd_mux;

  assign setup = (state == IDLE) && PSEL && !PENABLE;
  assign done  = (state == ACCESS) && PSEL && (wait_cnt == 4'd0);

  // Error is decided from the setup-phase bus values so that anything the
  // master does to PADDR/PWRITE during the access phase has no effect.
  assign setup_err = (PADDR[31:6] != BASE_ADDR[31:6]) ||
                     (PADDR[1:0] != 2'b00) ||
                     (PWRITE && ((PADDR[5:2] == ID_IDX) || (PADDR[5:2] == STATUS_IDX)));

  always_comb begin
    case (idx_q)
      ID_IDX:     rd_mux = ID_VALUE;
      STATUS_IDX: rd_mux = {16'h0, err_cnt};
      default:    rd_mux = regs[idx_q];
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (setup) state_nxt = ACCESS;
      // Completion and abort (PSEL dropped) both return to IDLE.
      ACCESS:  if (!PSEL || (wait_cnt == 4'd0)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign PREADY  = done;
  assign PSLVERR = done && err_q;
  assign PRDATA  = (done && !wr_q && !err_q) ? rd_mux : 32'h0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      idx_q    <= 4'd0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      err_cnt  <= 16'h0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'h0;
    end else begin
      state <= state_nxt;
      if (setup) begin
        wait_cnt <= 4'(WAIT_STATES);
        idx_q    <= PADDR[5:2];
        wr_q     <= PWRITE;
        err_q    <= setup_err;
      end else if ((state == ACCESS) && PSEL && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      // An errored write never reaches here, which also protects reg0/reg1.
      if (done && wr_q && !err_q) regs[idx_q] <= wdata_q;
      if (done && err_q && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (setup) wdata_q <= PWDATA;
  end

endmodule
